// File: rtl/udp_tx_scheduler_if.sv
// Descriptor-in / transmit-control bundle between the UDP receive side,
// the transmitter and udp_tx_scheduler. The scheduler connects to the slave modport.
interface udp_tx_scheduler_if #(
  parameter int LEN_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(LEN_DEPTH) + 1;

  logic             rec_end;
  logic [15:0]      rec_data_num;
  logic             send_end;
  logic             send_en;
  logic [15:0]      send_data_num;
  logic             drain_rd_en;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic [15:0]      drop_cnt;
  logic             timeout_flag;

  modport master (
    output rec_end, rec_data_num, send_end,
    input  send_en, send_data_num, drain_rd_en, busy, pend_cnt, drop_cnt, timeout_flag
  );

  modport slave (
    input  rec_end, rec_data_num, send_end,
    output send_en, send_data_num, drain_rd_en, busy, pend_cnt, drop_cnt, timeout_flag
  );
endinterface

// File: rtl/udp_tx_scheduler.sv
// Queues received-packet descriptors and paces transmissions (or drains rejected payload).
// Optional WAIT_END watchdog is compiled in when UDP_SCHED_TIMEOUT_EN is defined.
module udp_tx_scheduler #(
  parameter int          LEN_DEPTH      = 4,
  parameter logic [15:0] MAX_BYTES      = 16'd1472,
  parameter logic [15:0] GAP_CYCLES     = 16'd12,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
  input  logic              eth_tx_clk,
  input  logic              sys_rst_n,
  udp_tx_scheduler_if.slave bus
);
  localparam int          PTR_W    = $clog2(LEN_DEPTH);
  localparam int          CNT_W    = $clog2(LEN_DEPTH) + 1;
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 16'd0) ? 16'd0 : GAP_CYCLES - 16'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_END,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t           state_reg, state_next;
  logic [16:0]      desc_mem [LEN_DEPTH];
  logic [16:0]      rd_desc_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] pend_cnt_reg;
  logic [15:0]      drop_cnt_reg;
  logic [15:0]      send_data_num_reg;
  logic [14:0]      drain_cnt_reg;
  logic [15:0]      gap_cnt_reg;
  logic             in_discard, q_full, do_pop, do_push, do_drop;
  logic             wd_expired;
  logic             send_en_c, drain_rd_en_c, busy_c;

  assign in_discard = (bus.rec_data_num == 16'd0) || (bus.rec_data_num > MAX_BYTES);
  assign q_full     = (pend_cnt_reg == CNT_W'(LEN_DEPTH));
  assign do_pop     = (state_reg == S_IDLE) && (pend_cnt_reg != '0);
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_push    = bus.rec_end && (!q_full || do_pop);
  assign do_drop    = bus.rec_end && (in_discard || (q_full && !do_pop));

  // Descriptor store: {discard, len}, read registered on pop.
  always_ff @(posedge eth_tx_clk) begin
    if (do_push) begin
      desc_mem[wr_ptr_reg] <= {in_discard, bus.rec_data_num};
    end
    if (do_pop) begin
      rd_desc_reg <= desc_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge eth_tx_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pend_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   pend_cnt_reg <= pend_cnt_reg + 1'b1;
        2'b01:   pend_cnt_reg <= pend_cnt_reg - 1'b1;
        default: pend_cnt_reg <= pend_cnt_reg;
      endcase
      if (do_drop && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  // Per-packet datapath: length capture, drain word count, inter-packet gap timer.
  always_ff @(posedge eth_tx_clk) begin
    if (!sys_rst_n) begin
      send_data_num_reg <= '0;
      drain_cnt_reg     <= '0;
      gap_cnt_reg       <= '0;
    end else begin
      if (state_reg == S_LOAD) begin
        send_data_num_reg <= rd_desc_reg[15:0];
        drain_cnt_reg     <= 15'(({1'b0, rd_desc_reg[15:0]} + 17'd3) >> 2);
      end else if ((state_reg == S_DRAIN) && (drain_cnt_reg != '0)) begin
        drain_cnt_reg <= drain_cnt_reg - 15'd1;
      end
      if (state_reg != S_GAP) begin
        gap_cnt_reg <= GAP_LOAD;
      end else if (gap_cnt_reg != '0) begin
        gap_cnt_reg <= gap_cnt_reg - 16'd1;
      end
    end
  end

`ifdef UDP_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt_reg;
  logic        timeout_flag_reg;

  assign wd_expired = ({1'b0, wd_cnt_reg} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

  always_ff @(posedge eth_tx_clk) begin
    if (!sys_rst_n) begin
      wd_cnt_reg       <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      if (state_reg == S_WAIT_END) begin
        wd_cnt_reg <= wd_cnt_reg + 16'd1;
      end else begin
        wd_cnt_reg <= '0;
      end
      // A genuine send_end on the last allowed cycle wins over the watchdog.
      if ((state_reg == S_WAIT_END) && !bus.send_end && wd_expired) begin
        timeout_flag_reg <= 1'b1;
      end
    end
  end

  assign bus.timeout_flag = timeout_flag_reg;
`else
  assign wd_expired       = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  always_ff @(posedge eth_tx_clk) begin
    if (!sys_rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (do_pop) state_next = S_LOAD;
      S_LOAD:     state_next = rd_desc_reg[16] ? S_DRAIN : S_START;
      S_START:    state_next = S_WAIT_END;
      S_WAIT_END: if (bus.send_end || wd_expired) state_next = S_GAP;
      S_DRAIN:    if (drain_cnt_reg <= 15'd1) state_next = S_GAP;
      S_GAP:      if (gap_cnt_reg == '0) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    send_en_c     = 1'b0;
    drain_rd_en_c = 1'b0;
    busy_c        = 1'b1;
    case (state_reg)
      S_IDLE:  busy_c = 1'b0;
      S_START: send_en_c = 1'b1;
      S_DRAIN: drain_rd_en_c = (drain_cnt_reg != '0);
      default: ;
    endcase
  end

  assign bus.send_en       = send_en_c;
  assign bus.drain_rd_en   = drain_rd_en_c;
  assign bus.busy          = busy_c;
  assign bus.send_data_num = send_data_num_reg;
  assign bus.pend_cnt      = pend_cnt_reg;
  assign bus.drop_cnt      = drop_cnt_reg;
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Self-checking bench for udp_tx_scheduler: a timeline model of packet scheduling is
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_udp_tx_scheduler;
  localparam int D    = 4;
  localparam int MAXB = 1472;
  localparam int G    = 12;
  localparam int TO   = 4000;
  localparam int INF  = 32'h7fff_ffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  udp_tx_scheduler_if #(.LEN_DEPTH(D)) bus ();

  udp_tx_scheduler #(
    .LEN_DEPTH      (D),
    .MAX_BYTES      (16'd1472),
    .GAP_CYCLES     (16'd12),
    .TIMEOUT_CYCLES (16'd4000)
  ) dut (
    .eth_tx_clk (clk),
    .sys_rst_n  (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct {
    bit disc;
    int len;
  } desc_t;

  desc_t mq[$];
  bit    model_ok = 0;
  int    m_drop, m_sdn, m_sdn_pend, m_sdn_at;
  int    m_ev_start, m_dr_lo, m_dr_hi, m_idle_at;
  bit    m_wait, m_to;
  bit    mp_busy, mp_pop, mp_full, mp_disc;
  desc_t mp_head, mp_new;
  int    mp_words;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
        m_drop = 0; m_sdn = 0; m_sdn_pend = 0; m_sdn_at = -1;
        m_ev_start = -1; m_dr_lo = 1; m_dr_hi = 0; m_idle_at = 0;
        m_wait = 0; m_to = 0;
        model_ok = 1;
      end else if (model_ok) begin
        if (cyc == m_sdn_at) m_sdn = m_sdn_pend;
        mp_busy = m_wait || ((cyc - 1) < m_idle_at);
        if (m_wait && ((cyc - 1) > m_ev_start)) begin
          if (bus.send_end) begin
            m_wait = 0;
            m_idle_at = cyc + G;
          end
`ifdef UDP_SCHED_TIMEOUT_EN
          else if ((cyc - 1) == m_ev_start + TO) begin
            m_wait = 0;
            m_idle_at = cyc + G;
            m_to = 1;
          end
`endif
        end
        mp_pop  = !mp_busy && (mq.size() > 0);
        mp_full = (mq.size() == D);
        if (mp_pop) mp_head = mq.pop_front();
        if (bus.rec_end) begin
          mp_disc = (bus.rec_data_num == 16'd0) || (int'(bus.rec_data_num) > MAXB);
          if (!mp_full || mp_pop) begin
            mp_new.disc = mp_disc;
            mp_new.len  = int'(bus.rec_data_num);
            mq.push_back(mp_new);
          end
          if ((mp_disc || (mp_full && !mp_pop)) && (m_drop < 65535)) m_drop++;
        end
        if (mp_pop) begin
          m_sdn_pend = mp_head.len;
          m_sdn_at   = cyc + 1;
          if (!mp_head.disc) begin
            m_ev_start = cyc + 1;
            m_wait     = 1;
            m_idle_at  = INF;
          end else begin
            mp_words  = (mp_head.len + 3) / 4;
            m_dr_lo   = cyc + 1;
            m_dr_hi   = cyc + mp_words;
            m_idle_at = cyc + 1 + ((mp_words > 0) ? mp_words : 1) + G;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("send_en",       32'(bus.send_en),       32'(cyc == m_ev_start));
        check("drain_rd_en",   32'(bus.drain_rd_en),   32'((cyc >= m_dr_lo) && (cyc <= m_dr_hi)));
        check("busy",          32'(bus.busy),          32'(m_wait || (cyc < m_idle_at)));
        check("pend_cnt",      32'(bus.pend_cnt),      32'(mq.size()));
        check("drop_cnt",      32'(bus.drop_cnt),      32'(m_drop));
        check("send_data_num", 32'(bus.send_data_num), 32'(m_sdn));
        check("timeout_flag",  32'(bus.timeout_flag),  32'(m_to));
      end
    end
  end

  // ---------------- transmitter responder ----------------
  bit ack_en  = 0;
  bit spur_en = 0;
  int ack_min = 1;
  int ack_max = 1;

  initial begin
    int  cnt;
    bit  outst;
    cnt   = 0;
    outst = 0;
    bus.send_end = 1'b0;
    forever begin
      @(negedge clk);
      bus.send_end = 1'b0;
      if (!rst_n) begin
        outst = 0;
      end else if (bus.send_en === 1'b1) begin
        outst = 1;
        cnt   = int'($urandom_range(ack_max, ack_min));
      end else if (outst && ack_en) begin
        if (cnt <= 1) begin
          bus.send_end = 1'b1;
          outst = 0;
        end else begin
          cnt--;
        end
      end else if (!outst && spur_en && ($urandom_range(40, 0) == 0)) begin
        bus.send_end = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_rec(input int len);
    bus.rec_end      = 1'b1;
    bus.rec_data_num = 16'(len);
    $display("rec_end len=%0d cycle=%0d", len, cyc);
    @(negedge clk);
    bus.rec_end      = 1'b0;
  endtask

  task automatic wait_send_en(input string name, output int waited);
    bit seen;
    seen   = 0;
    waited = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      waited++;
      if (bus.send_en === 1'b1) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.pend_cnt === '0) ok = 1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  function automatic int rand_len();
    int sel;
    sel = int'($urandom_range(9, 0));
    case (sel)
      0:       return 0;
      1:       return MAXB;
      2:       return MAXB + 1;
      3:       return int'($urandom_range(2000, MAXB + 1));
      default: return int'($urandom_range(MAXB, 1));
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, w, coin, guard, cnt_se;
    bit found;
    bus.rec_end      = 1'b0;
    bus.rec_data_num = 16'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(bus.busy),          32'd0);
    check("rst_pend",    32'(bus.pend_cnt),      32'd0);
    check("rst_drop",    32'(bus.drop_cnt),      32'd0);
    check("rst_sdn",     32'(bus.send_data_num), 32'd0);
    check("rst_send_en", 32'(bus.send_en),       32'd0);
    rst_n = 1'b1;

    // Single packet of 100 bytes, send_end 5 cycles after send_en.
    ack_en = 1; ack_min = 5; ack_max = 5;
    @(negedge clk);
    drive_rec(100);
    wait_send_en("a_send_en_seen", w);
    check("a_latency", 32'(w), 32'd2);
    check("a_sdn", 32'(bus.send_data_num), 32'd100);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      if (bus.send_end === 1'b1) found = 1;
    end
    check("a_send_end_seen", 32'(found), 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
    end
    check("a_gap_busy_cycles", 32'(n), 32'd12);

    // Back-to-back 5 packets, then one overflow.
    ack_en = 0; ack_min = 2; ack_max = 6;
    @(negedge clk);
    for (int i = 0; i < 5; i++) drive_rec(8 * (i + 1));
    repeat (3) @(negedge clk);
    check("b_pend", 32'(bus.pend_cnt), 32'd4);
    check("b_drop", 32'(bus.drop_cnt), 32'd0);
    check("b_first_sdn", 32'(bus.send_data_num), 32'd8);
    drive_rec(48);
    @(negedge clk);
    check("c_drop", 32'(bus.drop_cnt), 32'd1);
    check("c_pend", 32'(bus.pend_cnt), 32'd4);
    ack_en = 1;
    for (int i = 1; i < 5; i++) begin
      wait_send_en("bc_send_en_seen", w);
      check("bc_order_sdn", 32'(bus.send_data_num), 32'(8 * (i + 1)));
    end
    wait_idle("bc_idle");
    cnt_se = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.send_en === 1'b1) cnt_se++;
    end
    check("c_no_sixth", 32'(cnt_se), 32'd0);

    // Discard: 1500 bytes drains 375 words; zero length drains nothing.
    drive_rec(1500);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.drain_rd_en === 1'b1) found = 1;
    end
    check("d_drain_seen", 32'(found), 32'd1);
    n = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.drain_rd_en !== 1'b1) break;
      n++;
    end
    check("d_drain_words", 32'(n), 32'd375);
    check("d_drop", 32'(bus.drop_cnt), 32'd2);
    wait_idle("d_idle");
    drive_rec(0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.drain_rd_en === 1'b1) n++;
    end
    check("d_zero_drain", 32'(n), 32'd0);
    check("d_zero_drop", 32'(bus.drop_cnt), 32'd3);

    // Keep the queue full and push exactly on the IDLE pop.
    ack_en = 1; ack_min = 1; ack_max = 4;
    coin = 0; guard = 0;
    while (coin < 20 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (bus.pend_cnt == 3'(D) && bus.busy === 1'b0) begin
        drive_rec(int'($urandom_range(MAXB, 1)));
        check("e_pend_hold", 32'(bus.pend_cnt), 32'(D));
        coin++;
      end else if (bus.pend_cnt < 3'(D)) begin
        drive_rec(int'($urandom_range(MAXB, 1)));
      end
    end
    check("e_coincident", 32'(coin), 32'd20);
    wait_idle("e_idle");

    // Watchdog behaviour with send_end withheld.
    ack_en = 0;
    drive_rec(200);
    wait_send_en("f_send_en_seen", w);
`ifdef UDP_SCHED_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      n++;
      if (bus.timeout_flag === 1'b1) break;
    end
    check("f_timeout_cycles", 32'(n), 32'd4001);
    check("f_timeout_flag", 32'(bus.timeout_flag), 32'd1);
    wait_idle("f_idle_after_timeout");
    drive_rec(300);
    wait_send_en("f_send_en2_seen", w);
    repeat (3) @(negedge clk);
`else
    repeat (4100) @(negedge clk);
    check("f_still_busy", 32'(bus.busy), 32'd1);
    check("f_no_flag", 32'(bus.timeout_flag), 32'd0);
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("f_rst_busy",    32'(bus.busy),          32'd0);
    check("f_rst_send_en", 32'(bus.send_en),       32'd0);
    check("f_rst_drain",   32'(bus.drain_rd_en),   32'd0);
    check("f_rst_sdn",     32'(bus.send_data_num), 32'd0);
    check("f_rst_drop",    32'(bus.drop_cnt),      32'd0);
    check("f_rst_flag",    32'(bus.timeout_flag),  32'd0);
    rst_n = 1'b1;

    // Random traffic with spurious send_end and occasional resets.
    ack_en = 1; ack_min = 1; ack_max = 15; spur_en = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(599, 0) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else if ($urandom_range(5, 0) == 0) begin
        drive_rec(rand_len());
      end
    end

    // drop_cnt saturation.
    spur_en = 0; ack_en = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_rec(64);
    bus.rec_end      = 1'b1;
    bus.rec_data_num = 16'd0;
    repeat (65540) @(negedge clk);
    bus.rec_end = 1'b0;
    @(negedge clk);
    check("h_drop_saturated", 32'(bus.drop_cnt), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/udp_tx_scheduler.md
UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 SHALL provide parameters: LEN_DEPTH, default 4, packet-descriptor queue depth (power of 2, 2..16); MAX_BYTES, default 16'd1472, largest payload forwarded; GAP_CYCLES, default 16'd12, idle cycles between transmissions; TIMEOUT_CYCLES, default 16'd4000, send_end watchdog limit.
REQ-002 SHALL provide ports (name direction width meaning):
- eth_tx_clk  in  1  MII clock, single clock domain.
- sys_rst_n  in  1  synchronous active-low reset.
- rec_end  in  1  one-cycle pulse, receive packet complete.
- rec_data_num  in  16  payload byte count, valid with rec_end.
- send_end  in  1  one-cycle pulse, transmitter finished packet.
- send_en  out  1  one-cycle transmit start pulse.
- send_data_num  out  16  payload byte count for the current transmission.
- drain_rd_en  out  1  data-FIFO pop used to discard rejected payload.
- busy  out  1  high in any state other than IDLE.
- pend_cnt  out  $clog2(LEN_DEPTH)+1  queued descriptors.
- drop_cnt  out  16  rejected/overflowed packets, saturating.
- timeout_flag  out  1  sticky watchdog indication.
REQ-003 SHALL use one clock and a synchronous, active-low reset: eth_tx_clk and sys_rst_n.

Function
REQ-004 SHALL queue one descriptor {discard, len[15:0]} per rec_end in a LEN_DEPTH-entry circular buffer with wrap-around read/write pointers.
REQ-005 SHALL set discard=1 when rec_data_num==0 or rec_data_num>MAX_BYTES, and increment drop_cnt for each such packet.
REQ-006 SHALL, when rec_end arrives with the queue full and no pop in the same cycle, not store the descriptor and increment drop_cnt.
REQ-007 SHALL accept a push when the queue is full if a pop occurs in the same cycle; simultaneous push+pop leaves pend_cnt unchanged.
REQ-008 SHALL saturate drop_cnt at 16'hFFFF.
REQ-009 SHALL implement the states IDLE, LOAD, START, WAIT_END, DRAIN and GAP.
REQ-010 SHALL, in IDLE with pend_cnt>0, pop the head descriptor and move to LOAD.
REQ-011 SHALL, in LOAD, register len into send_data_num, then move to DRAIN if discard=1, else to START.
REQ-012 SHALL, in START, assert send_en for exactly one cycle and then move to WAIT_END, so send_en is high 2 cycles after the pop.
REQ-013 SHALL, in WAIT_END, move to GAP on send_end; a send_end received in any other state SHALL be ignored.
REQ-014 SHALL, in DRAIN, assert drain_rd_en for exactly ceil(len/4) consecutive cycles (0 cycles when len==0), then move to GAP; a len>MAX_BYTES still drains ceil(len/4) words.
REQ-015 SHALL, in GAP, remain GAP_CYCLES cycles (GAP_CYCLES==0 means one cycle), then move to IDLE.
REQ-016 SHALL hold send_data_num stable from LOAD until the next LOAD.
REQ-017 SHALL never assert send_en and drain_rd_en in the same cycle.

Reset
REQ-018 SHALL, while sys_rst_n is low at an eth_tx_clk edge, force: state to IDLE, both pointers and pend_cnt to 0, send_en=0, drain_rd_en=0, send_data_num=0, busy=0, drop_cnt=0, timeout_flag=0.
REQ-019 SHALL, when reset is applied mid-transmission or mid-drain, abandon that descriptor and drive no further pulses for it.

Configuration
REQ-020 SHALL compile the WAIT_END watchdog only when UDP_SCHED_TIMEOUT_EN is defined: after TIMEOUT_CYCLES cycles in WAIT_END without send_end, it moves to GAP and sets timeout_flag, which clears only on reset.
REQ-021 SHALL, without UDP_SCHED_TIMEOUT_EN, wait in WAIT_END indefinitely and tie timeout_flag to 0.

Verification
REQ-022 Single packet: rec_end with rec_data_num=100 while idle -> send_en one pulse 2 cycles after the pop, send_data_num=100; after send_end, busy stays high 12 cycles then falls.
REQ-023 Back-to-back: 5 rec_end pulses (len 8,16,24,32,40) before any send_end with LEN_DEPTH=4 -> first popped immediately, remaining 4 queued, none lost, drop_cnt=0; transmitted in order.
REQ-024 Overflow: fill the queue while in WAIT_END, then one more rec_end -> drop_cnt=1, pend_cnt=4, the 6th descriptor is not transmitted.
REQ-025 Discard: rec_data_num=1500 -> no send_en, drain_rd_en high 375 consecutive cycles, drop_cnt+1; rec_data_num=0 -> no drain cycles.
REQ-026 Wrap and simultaneity: 20 packets with rec_end coincident with the IDLE pop on a full queue -> accepted, pend_cnt unchanged, FIFO order preserved across pointer wrap.
REQ-027 Watchdog: with UDP_SCHED_TIMEOUT_EN defined and send_end withheld -> GAP entered after 4000 cycles and timeout_flag=1; without the macro -> state stays WAIT_END and timeout_flag=0; sys_rst_n low mid-WAIT_END -> all outputs return to 0.
